// File: rtl/booth_mul_pkg.sv
// Shared FSM state encoding and radix-4 Booth digit select codes.
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_e;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_sel_e booth_decode(input logic [2:0] bits);
        booth_sel_e sel;
        case (bits)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_radix4_encoder.sv
// Decodes one radix-4 Booth digit and selects the partial product {0, +-M, +-2M}.
// Purely combinational; M is already extended to MUL_WIDTH+2 bits so +-2M cannot overflow.
module booth_radix4_encoder
    import booth_mul_pkg::*;
#(
    parameter int MUL_WIDTH = 8
) (
    input  logic [2:0]           bits_i,
    input  logic [MUL_WIDTH+1:0] mcand_i,
    output logic [MUL_WIDTH+1:0] pp_o
);

    booth_sel_e sel;

    always_comb begin
        sel  = booth_decode(bits_i);
        pp_o = '0;
        case (sel)
            POS1:    pp_o = mcand_i;
            POS2:    pp_o = mcand_i << 1;
            NEG1:    pp_o = -mcand_i;
            NEG2:    pp_o = -(mcand_i << 1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per request, one digit per CALC cycle.
// Optional macro BOOTH_MUL_ACCUMULATE_EN adds an accumulate input that sums products into data_out.
module booth_radix4_multiplier
    import booth_mul_pkg::*;
#(
    parameter int MUL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sign,
    input  logic [MUL_WIDTH-1:0]     data_in1,
    input  logic [MUL_WIDTH-1:0]     data_in2,
    output logic [2*MUL_WIDTH-1:0]   data_out,
    output logic                     ready,
    output logic                     busy
`ifdef BOOTH_MUL_ACCUMULATE_EN
    ,
    input  logic                     accumulate
`endif
);

    localparam int K  = MUL_WIDTH / 2 + 1;
    localparam int CW = $clog2(K + 1);
    localparam int PW = 2 * MUL_WIDTH;
    localparam int LW = MUL_WIDTH + 2;
    localparam int HW = MUL_WIDTH + 4;

    state_e          state_q;
    logic [LW-1:0]   mcand_q;
    logic [HW-1:0]   hi_q;
    logic [LW-1:0]   lo_q;
    logic            prev_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   data_out_q;
    logic            ready_q;
    logic            busy_q;
`ifdef BOOTH_MUL_ACCUMULATE_EN
    logic            acc_en_q;
`endif

    logic [LW-1:0]   pp;
    logic [HW-1:0]   sum;
    logic [HW-1:0]   hi_d;
    logic [LW-1:0]   lo_d;
    logic            prev_d;
    logic [PW-1:0]   product;
    logic [PW-1:0]   result_d;

    booth_radix4_encoder #(
        .MUL_WIDTH (MUL_WIDTH)
    ) u_enc (
        .bits_i  ({lo_q[1:0], prev_q}),
        .mcand_i (mcand_q),
        .pp_o    (pp)
    );

    // {hi, lo} is the shifting product register; consumed multiplier bits leave through lo.
    always_comb begin
        sum     = hi_q + {{2{pp[LW-1]}}, pp};
        hi_d    = {{2{sum[HW-1]}}, sum[HW-1:2]};
        lo_d    = {sum[1:0], lo_q[LW-1:2]};
        prev_d  = lo_q[1];
        product = {hi_q[MUL_WIDTH-3:0], lo_q};
`ifdef BOOTH_MUL_ACCUMULATE_EN
        result_d = acc_en_q ? (data_out_q + product) : product;
`else
        result_d = product;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef BOOTH_MUL_ACCUMULATE_EN
            acc_en_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        mcand_q <= sign ? {{2{data_in1[MUL_WIDTH-1]}}, data_in1}
                                        : {2'b00, data_in1};
                        lo_q    <= sign ? {{2{data_in2[MUL_WIDTH-1]}}, data_in2}
                                        : {2'b00, data_in2};
                        hi_q    <= '0;
                        prev_q  <= 1'b0;
                        cnt_q   <= '0;
`ifdef BOOTH_MUL_ACCUMULATE_EN
                        acc_en_q <= accumulate;
`endif
                    end
                end
                CALC: begin
                    if (cnt_q != CW'(K)) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        prev_q <= prev_d;
                        cnt_q  <= cnt_q + CW'(1);
                    end else begin
                        state_q    <= DONE;
                        data_out_q <= result_d;
                        ready_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for the radix-4 Booth multiplier at MUL_WIDTH=4 and a strided MUL_WIDTH=8 sweep.
module tb_booth_radix4_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, sign4;
    logic [3:0] a4, b4;
    logic [7:0] dout4;
    logic       rdy4, busy4;
    logic       start8, sign8;
    logic [7:0] a8, b8;
    logic [15:0] dout8;
    logic       rdy8, busy8;
`ifdef BOOTH_MUL_ACCUMULATE_EN
    logic       acc4, acc8;
`endif

    int tests = 0;
    int fails = 0;

    booth_radix4_multiplier #(.MUL_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sign(sign4),
        .data_in1(a4), .data_in2(b4), .data_out(dout4), .ready(rdy4), .busy(busy4)
`ifdef BOOTH_MUL_ACCUMULATE_EN
        , .accumulate(acc4)
`endif
    );

    booth_radix4_multiplier #(.MUL_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sign(sign8),
        .data_in1(a8), .data_in2(b8), .data_out(dout8), .ready(rdy8), .busy(busy8)
`ifdef BOOTH_MUL_ACCUMULATE_EN
        , .accumulate(acc8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one W=4 operation, check latency, product and the return to IDLE.
    task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input string tag);
        int n;
        sign4 = s; a4 = a; b4 = b; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        while (!rdy4 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check(tag, dout4, exp);
        check({tag, "_busy_done"}, busy4, 1);
        tick();
        check({tag, "_ready_drop"}, rdy4, 0);
        check({tag, "_busy_idle"}, busy4, 0);
    endtask

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
        int n;
        sign8 = s; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!rdy8 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("w8_lat s%0d %0h*%0h", s, a, b), n, 6);
        check($sformatf("w8 s%0d %0h*%0h", s, a, b), dout8, exp);
        tick();
    endtask

    initial begin
        logic [7:0]  avals [10];
        logic [15:0] exp16;
        logic [7:0]  bv;
        int          nrdy;
        logic [7:0]  seen;

        avals = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'h55, 8'hAA, 8'h3C};
        rst = 1'b1;
        start4 = 1'b0; sign4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sign8 = 1'b0; a8 = '0; b8 = '0;
`ifdef BOOTH_MUL_ACCUMULATE_EN
        acc4 = 1'b0; acc8 = 1'b0;
`endif
        tick();
        tick();
        check("rst_dout4", dout4, 0);
        check("rst_ready4", rdy4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_dout8", dout8, 0);
        rst = 1'b0;
        tick();

        run4(1'b1, 4'h9, 4'hE, 8'h0E, "m7_x_m2");
        run4(1'b0, 4'hF, 4'hF, 8'hE1, "u15_x_15");
        run4(1'b1, 4'hF, 4'hF, 8'h01, "s_m1_x_m1");
        run4(1'b1, 4'h8, 4'h8, 8'h40, "s_m8_x_m8");
        run4(1'b1, 4'h8, 4'h7, 8'hC8, "s_m8_x_7");
        run4(1'b0, 4'hF, 4'h8, 8'h78, "u15_x_8");
        run4(1'b1, 4'h7, 4'hF, 8'hF9, "s7_x_m1");
        run4(1'b0, 4'h0, 4'h9, 8'h00, "u0_x_9");

        // Second start during CALC must be dropped.
        sign4 = 1'b0; a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        a4 = 4'h7; b4 = 4'h7; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        nrdy = 0;
        seen = '0;
        for (int i = 0; i < 12; i++) begin
            if (rdy4) begin
                nrdy++;
                seen = dout4;
            end
            tick();
        end
        check("ignore_start_pulses", nrdy, 1);
        check("ignore_start_dout", seen, 8'h0F);

        // Reset at edge t+2 of an operation.
        sign4 = 1'b0; a4 = 4'h5; b4 = 4'h5; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_dout", dout4, 0);
        check("abort_busy", busy4, 0);
        nrdy = 0;
        for (int i = 0; i < 10; i++) begin
            if (rdy4) nrdy++;
            tick();
        end
        check("abort_no_ready", nrdy, 0);
        run4(1'b0, 4'h3, 4'h7, 8'h15, "after_abort_3x7");

`ifdef BOOTH_MUL_ACCUMULATE_EN
        acc4 = 1'b0;
        run4(1'b0, 4'h3, 4'h5, 8'h0F, "acc_first");
        acc4 = 1'b1;
        run4(1'b0, 4'h2, 4'h2, 8'h13, "acc_second");
        acc4 = 1'b0;
`endif

        for (int i = 0; i < 10; i++) begin
            for (int b = 0; b < 256; b++) begin
                bv = b[7:0];
                exp16 = {8'h00, avals[i]} * {8'h00, bv};
                run8(1'b0, avals[i], bv, exp16);
                exp16 = $signed({{8{avals[i][7]}}, avals[i]}) * $signed({{8{bv[7]}}, bv});
                run8(1'b1, avals[i], bv, exp16);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
